// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back stage: derives register IDs from the fetched
// fields, holds the 15 x 64-bit register file and commits valE/valM on clk.
module decode_writeback #(
  parameter bit         BYPASS = 1'b0,
  parameter logic [3:0] RSP_ID = 4'h4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  rA_i,
  input  logic [3:0]  rB_i,
  input  logic        cnd_i,
  input  logic        wb_en_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valM_i,
  output logic [3:0]  srcA_o,
  output logic [3:0]  srcB_o,
  output logic [3:0]  dstE_o,
  output logic [3:0]  dstM_o,
  output logic [63:0] valA_o,
  output logic [63:0] valB_o
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE = 4'hF;

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];
  logic [63:0] storedA, storedB;
  logic        byp_ok;

  always_comb begin
    srcA_o = RNONE;
    srcB_o = RNONE;
    dstE_o = RNONE;
    dstM_o = RNONE;
    case (icode_i)
      I_RRMOVQ: begin
        srcA_o = rA_i;
        dstE_o = cnd_i ? rB_i : RNONE;
      end
      I_IRMOVQ: dstE_o = rB_i;
      I_RMMOVQ: begin
        srcA_o = rA_i;
        srcB_o = rB_i;
      end
      I_MRMOVQ: begin
        srcB_o = rB_i;
        dstM_o = rA_i;
      end
      I_OPQ: begin
        srcA_o = rA_i;
        srcB_o = rB_i;
        dstE_o = rB_i;
      end
      I_CALL: begin
        srcB_o = RSP_ID;
        dstE_o = RSP_ID;
      end
      I_RET: begin
        srcA_o = RSP_ID;
        srcB_o = RSP_ID;
        dstE_o = RSP_ID;
      end
      I_PUSHQ: begin
        srcA_o = rA_i;
        srcB_o = RSP_ID;
        dstE_o = RSP_ID;
      end
      I_POPQ: begin
        srcA_o = RSP_ID;
        srcB_o = RSP_ID;
        dstE_o = RSP_ID;
        dstM_o = rA_i;
      end
      default: ;
    endcase
  end

  // M is applied after E so it wins when both target the same register.
  always_comb begin
    for (int unsigned i = 0; i < 15; i++) regs_d[i] = regs_q[i];
    if (wb_en_i) begin
      if (dstE_o != RNONE) regs_d[dstE_o] = valE_i;
      if (dstM_o != RNONE) regs_d[dstM_o] = valM_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign byp_ok = BYPASS && wb_en_i && rst_n_i;

  always_comb begin
    storedA = (srcA_o == RNONE) ? '0 : regs_q[srcA_o];
    storedB = (srcB_o == RNONE) ? '0 : regs_q[srcB_o];
    valA_o  = storedA;
    valB_o  = storedB;
    if (byp_ok && srcA_o != RNONE) begin
      if (srcA_o == dstM_o)      valA_o = valM_i;
      else if (srcA_o == dstE_o) valA_o = valE_i;
    end
    if (byp_ok && srcB_o != RNONE) begin
      if (srcB_o == dstM_o)      valB_o = valM_i;
      else if (srcB_o == dstE_o) valB_o = valE_i;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: one instance without and one with
// write-through bypass, driven by identical directed vectors.
module tb_decode_writeback;

  logic        clk, rst_n;
  logic [3:0]  icode, rA, rB;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;

  logic [3:0]  srcA0, srcB0, dstE0, dstM0, srcA1, srcB1, dstE1, dstM1;
  logic [63:0] valA0, valB0, valA1, valB1;

  decode_writeback #(.BYPASS(1'b0), .RSP_ID(4'h4)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .icode_i(icode), .rA_i(rA), .rB_i(rB),
    .cnd_i(cnd), .wb_en_i(wb_en), .valE_i(valE), .valM_i(valM),
    .srcA_o(srcA0), .srcB_o(srcB0), .dstE_o(dstE0), .dstM_o(dstM0),
    .valA_o(valA0), .valB_o(valB0)
  );

  decode_writeback #(.BYPASS(1'b1), .RSP_ID(4'h4)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .icode_i(icode), .rA_i(rA), .rB_i(rB),
    .cnd_i(cnd), .wb_en_i(wb_en), .valE_i(valE), .valM_i(valM),
    .srcA_o(srcA1), .srcB_o(srcB1), .dstE_o(dstE1), .dstM_o(dstM1),
    .valA_o(valA1), .valB_o(valB1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_SRCA = 0, K_SRCB = 1, K_DSTE = 2, K_DSTM = 3;
  localparam int K_VA0 = 4, K_VB0 = 5, K_VA1 = 6, K_VB1 = 7, K_IDS1 = 8;

  typedef struct {
    string       name;
    int          kind;
    logic [63:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  task automatic expect_v(input string n, input int k, input logic [63:0] e);
    sb.push_back('{n, k, e});
  endtask

  task automatic expect_ids(input string n, input logic [3:0] sa, input logic [3:0] sbv,
                            input logic [3:0] de, input logic [3:0] dm);
    expect_v({n, ".srcA"}, K_SRCA, {60'd0, sa});
    expect_v({n, ".srcB"}, K_SRCB, {60'd0, sbv});
    expect_v({n, ".dstE"}, K_DSTE, {60'd0, de});
    expect_v({n, ".dstM"}, K_DSTM, {60'd0, dm});
  endtask

  task automatic settle();
    #1;
    ->chk_ev;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic wb, input logic [63:0] ve,
                       input logic [63:0] vm);
    @(negedge clk);
    icode = ic; rA = ra; rB = rb; cnd = c; wb_en = wb; valE = ve; valM = vm;
  endtask

  // Read registers a/b through OPQ with commit disabled.
  task automatic read_regs(input string n, input logic [3:0] a, input logic [3:0] b,
                           input logic [63:0] ea, input logic [63:0] eb);
    drive(4'h6, a, b, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_v({n, ".valA0"}, K_VA0, ea);
    expect_v({n, ".valB0"}, K_VB0, eb);
    expect_v({n, ".valA1"}, K_VA1, ea);
    expect_v({n, ".valB1"}, K_VB1, eb);
    settle();
  endtask

  initial begin : monitor
    chk_t        c;
    logic [63:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.kind)
          K_SRCA:  act = {60'd0, srcA0};
          K_SRCB:  act = {60'd0, srcB0};
          K_DSTE:  act = {60'd0, dstE0};
          K_DSTM:  act = {60'd0, dstM0};
          K_VA0:   act = valA0;
          K_VB0:   act = valB0;
          K_VA1:   act = valA1;
          K_VB1:   act = valB1;
          default: act = {48'd0, srcA1, srcB1, dstE1, dstM1};
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0; wb_en = 1'b0;
    valE = '0; valM = '0;

    for (int i = 0; i < 15; i++) begin
      drive(4'h6, 4'(i), 4'(i), 1'b0, 1'b0, 64'h0, 64'h0);
      expect_v($sformatf("rst_r%0d.valA0", i), K_VA0, 64'h0);
      expect_v($sformatf("rst_r%0d.valB0", i), K_VB0, 64'h0);
      settle();
    end

    // IRMOVQ rB=2
    drive(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 64'h1234, 64'h0);
    rst_n = 1'b1;
    expect_ids("irmovq", 4'hF, 4'hF, 4'h2, 4'hF);
    settle();
    drive(4'h6, 4'h2, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_ids("opq22", 4'h2, 4'h2, 4'h2, 4'hF);
    expect_v("opq22.valA0", K_VA0, 64'h1234);
    expect_v("opq22.valB0", K_VB0, 64'h1234);
    settle();

    // POPQ %rsp: M wins over E
    drive(4'hB, 4'h4, 4'hF, 1'b0, 1'b1, 64'h108, 64'hBEEF);
    expect_ids("popq", 4'h4, 4'h4, 4'h4, 4'h4);
    expect_v("popq.valA0_old", K_VA0, 64'h0);
    expect_v("popq.valA1_byp", K_VA1, 64'hBEEF);
    expect_v("popq.valB1_byp", K_VB1, 64'hBEEF);
    settle();
    read_regs("after_popq", 4'h4, 4'h2, 64'hBEEF, 64'h1234);

    // RRMOVQ (cmovle) rA=1 rB=3
    drive(4'h2, 4'h1, 4'h3, 1'b0, 1'b1, 64'h55, 64'h0);
    expect_ids("cmov_nc", 4'h1, 4'hF, 4'hF, 4'hF);
    settle();
    read_regs("cmov_nc_r3", 4'h3, 4'h3, 64'h0, 64'h0);
    drive(4'h2, 4'h1, 4'h3, 1'b1, 1'b1, 64'h55, 64'h0);
    expect_v("cmov_c.dstE", K_DSTE, 64'h3);
    settle();
    read_regs("cmov_c_r3", 4'h3, 4'h3, 64'h55, 64'h55);

    // wb_en gating
    drive(4'h3, 4'hF, 4'h5, 1'b0, 1'b1, 64'h77, 64'h0);
    drive(4'h3, 4'hF, 4'h5, 1'b0, 1'b0, 64'hFF, 64'h0);
    expect_v("noen.dstE", K_DSTE, 64'h5);
    settle();
    read_regs("noen_r5", 4'h5, 4'h5, 64'h77, 64'h77);
    drive(4'h6, 4'h5, 4'h5, 1'b0, 1'b0, 64'hFF, 64'h0);
    expect_v("noen_byp.valA1", K_VA1, 64'h77);
    settle();

    // Invalid icodes D and C, plus RET decode
    drive(4'hD, 4'h5, 4'h5, 1'b1, 1'b1, 64'h99, 64'h99);
    expect_ids("icodeD", 4'hF, 4'hF, 4'hF, 4'hF);
    expect_v("icodeD.ids1", K_IDS1, 64'hFFFF);
    settle();
    read_regs("icodeD_r5", 4'h5, 4'h5, 64'h77, 64'h77);
    drive(4'hC, 4'h1, 4'h2, 1'b1, 1'b0, 64'h0, 64'h0);
    expect_ids("icodeC", 4'hF, 4'hF, 4'hF, 4'hF);
    settle();
    drive(4'h9, 4'h1, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_ids("ret", 4'h4, 4'h4, 4'h4, 4'hF);
    settle();
    drive(4'h5, 4'h7, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_ids("mrmovq", 4'hF, 4'h2, 4'hF, 4'h7);
    settle();
    drive(4'hA, 4'h3, 4'h2, 1'b0, 1'b0, 64'h0, 64'h0);
    expect_ids("pushq", 4'h3, 4'h4, 4'h4, 4'hF);
    expect_v("pushq.valA0", K_VA0, 64'h55);
    settle();

    // CALL: bypass shows new %rsp before the edge, non-bypass shows old
    drive(4'h8, 4'hF, 4'hF, 1'b0, 1'b1, 64'h200, 64'h0);
    expect_ids("call", 4'hF, 4'h4, 4'h4, 4'hF);
    expect_v("call.valB0_old", K_VB0, 64'hBEEF);
    expect_v("call.valB1_byp", K_VB1, 64'h200);
    settle();
    read_regs("after_call", 4'h4, 4'h3, 64'h200, 64'h55);

    // Asynchronous reset between edges with a pending write
    drive(4'h6, 4'h2, 4'h3, 1'b0, 1'b1, 64'h777, 64'h0);
    #2;
    rst_n = 1'b0;
    expect_v("midrst.valA0", K_VA0, 64'h0);
    expect_v("midrst.valB0", K_VB0, 64'h0);
    expect_v("midrst.valA1", K_VA1, 64'h0);
    expect_v("midrst.valB1", K_VB1, 64'h0);
    settle();
    drive(4'h6, 4'h2, 4'h3, 1'b0, 1'b0, 64'h0, 64'h0);
    rst_n = 1'b1;
    settle();
    read_regs("postrst", 4'h3, 4'h4, 64'h0, 64'h0);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
